// File: rtl/music_player_mcu.sv
// Music player master control: sequences song reader play/reset and song index.
// Optional AUTO_NEXT_EN: end of song advances to the next song and keeps playing.
module music_player_mcu #(
    parameter int NUM_SONGS  = 4,
    parameter int SONG_W     = 2,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              song_done,
    output logic              play,
    output logic              reset_player,
    output logic [SONG_W-1:0] song
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RST_CYCLES - 1);
    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

    typedef enum logic [1:0] {
        S_RESET_PLAYER,
        S_PAUSED,
        S_PLAYING,
        S_NEXT_SONG
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic              resume;
    logic              resume_n;
    logic              holding;
    logic              hold_done;
    logic [SONG_W-1:0] song_inc;

    assign holding   = (state == S_RESET_PLAYER) || (state == S_NEXT_SONG);
    assign hold_done = (cnt == CNT_MAX);
    assign song_inc  = (song == LAST_SONG) ? '0 : song + 1'b1;

    always_comb begin
        state_n  = state;
        resume_n = resume;
        unique case (state)
            S_RESET_PLAYER: begin
                if (hold_done) state_n = S_PAUSED;
            end
            S_PAUSED: begin
                if (next_button) begin
                    state_n  = S_NEXT_SONG;
                    resume_n = 1'b0;
                end else if (play_button) begin
                    state_n = S_PLAYING;
                end
            end
            S_PLAYING: begin
                if (next_button) begin
                    state_n  = S_NEXT_SONG;
                    resume_n = 1'b1;
                end else if (song_done) begin
`ifdef AUTO_NEXT_EN
                    state_n  = S_NEXT_SONG;
                    resume_n = 1'b1;
`else
                    state_n  = S_RESET_PLAYER;
`endif
                end else if (play_button) begin
                    state_n = S_PAUSED;
                end
            end
            S_NEXT_SONG: begin
                if (hold_done) state_n = resume ? S_PLAYING : S_PAUSED;
            end
            default: state_n = S_RESET_PLAYER;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_RESET_PLAYER;
            cnt    <= '0;
            resume <= 1'b0;
            song   <= '0;
        end else begin
            state  <= state_n;
            resume <= resume_n;
            if (state_n != state) cnt <= '0;
            else if (holding)     cnt <= cnt + 1'b1;
            // Index moves on entry so it is stable across the whole reset window
            if (state_n == S_NEXT_SONG && state != S_NEXT_SONG) song <= song_inc;
        end
    end

    assign play         = (state == S_PLAYING);
    assign reset_player = holding;

endmodule
